// File: rtl/rst_req_gen.sv
// Reset request generator: stretches synchronous reset requests into a minimum-width
// active-low request and completes the entry/exit handshake with the downstream synchronizer.
// Define RST_REQ_GEN_TIMEOUT_EN to add per-phase timeout supervision reported on timeout_o.
module rst_req_gen #(
    parameter int NumSrc          = 2,
    parameter int MinAssertCycles = 8,
    parameter int TimeoutCycles   = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic [NumSrc-1:0] req_i,
    input  logic [NumSrc-1:0] req_mask_i,
    input  logic              init_ni,
    output logic              rst_req_no,
    output logic              busy_o,
    output logic [NumSrc-1:0] cause_o,
    input  logic              cause_clr_i,
    output logic              timeout_o
);

    localparam int MaxCnt = (MinAssertCycles > TimeoutCycles) ? MinAssertCycles : TimeoutCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] MinLoad = CntW'(MinAssertCycles - 1);
    localparam logic [CntW-1:0] TmoLoad = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};

`ifdef RST_REQ_GEN_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    if (NumSrc < 1) begin : g_chk_num_src
        $fatal(1, "rst_req_gen: NumSrc must be >= 1");
    end
    if (MinAssertCycles < 1) begin : g_chk_min_assert
        $fatal(1, "rst_req_gen: MinAssertCycles must be >= 1");
    end
    if (TimeoutCycles < 1) begin : g_chk_timeout
        $fatal(1, "rst_req_gen: TimeoutCycles must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    state_e            state_r, state_s;
    logic [CntW-1:0]   cnt_r, cnt_s;
    logic              wait_r, wait_s;
    logic [NumSrc-1:0] eff_s;
    logic [NumSrc-1:0] cause_r, cause_s;
    logic              cnt_zero_s;
    logic              tmo_evt_s;
    logic              timeout_r, timeout_s;
    logic              rst_req_n_r;
    logic              busy_r;

    assign eff_s      = req_i & ~req_mask_i;
    assign cnt_zero_s = (cnt_r == CntZero);

    // Clear-then-set: a source requesting in the clear cycle stays recorded.
    assign cause_s   = (cause_clr_i ? {NumSrc{1'b0}} : cause_r) | eff_s;
    assign timeout_s = tmo_evt_s ? 1'b1 : (cause_clr_i ? 1'b0 : timeout_r);

    // Next-state, counter and wait-phase flag; wait_r marks ASSERT after the minimum width
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_zero_s ? cnt_r : (cnt_r - CntOne);
        wait_s    = wait_r;
        tmo_evt_s = 1'b0;
        if (test_mode_i) begin
            state_s = ST_IDLE;
            wait_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wait_s = 1'b0;
                    if (|eff_s) begin
                        state_s = ST_ASSERT;
                        cnt_s   = MinLoad;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    if ((cnt_zero_s || wait_r) && !init_ni) begin
                        state_s = ST_RELEASE;
                        cnt_s   = TmoLoad;
                        wait_s  = 1'b0;
                    end else if (!cnt_zero_s) begin
                        state_s = ST_ASSERT;
                    end else if (TmoEn && !wait_r) begin
                        wait_s = 1'b1;
                        cnt_s  = TmoLoad;
                    end else if (TmoEn) begin
                        tmo_evt_s = 1'b1;
                        state_s   = ST_RELEASE;
                        cnt_s     = TmoLoad;
                        wait_s    = 1'b0;
                    end else begin
                        state_s = ST_ASSERT;
                    end
                end
                ST_RELEASE: begin
                    if (init_ni) begin
                        state_s = ST_IDLE;
                    end else if (TmoEn && cnt_zero_s) begin
                        tmo_evt_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    wait_s  = 1'b0;
                end
            endcase
        end
    end

    // FSM state, phase counter and wait flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CntZero;
            wait_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            wait_r  <= wait_s;
        end
    end

    // Registered outputs are decoded from the next state so they align with the FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_req_n_r <= 1'b1;
            busy_r      <= 1'b0;
            cause_r     <= {NumSrc{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            rst_req_n_r <= (state_s != ST_ASSERT);
            busy_r      <= (state_s != ST_IDLE);
            cause_r     <= cause_s;
            timeout_r   <= timeout_s;
        end
    end

    assign rst_req_no = rst_req_n_r;
    assign busy_o     = busy_r;
    assign cause_o    = cause_r;
    assign timeout_o  = timeout_r & TmoEn;

endmodule

// File: tb/tb_rst_req_gen.sv
// Bench for rst_req_gen: single-cycle vector table, handshake corner sequences and random
// traffic checked against a phase/age reference model of the request/handshake rules.
`timescale 1ns/1ps
module tb_rst_req_gen;
    localparam int NS  = 2;
    localparam int MIN = 8;
    localparam int TMO = 16;
`ifdef RST_REQ_GEN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_ni    = 1'b0;
    logic          test_mode = 1'b0;
    logic [NS-1:0] req       = 2'b00;
    logic [NS-1:0] mask      = 2'b00;
    logic          init_ni   = 1'b1;
    logic          cause_clr = 1'b0;
    logic          rst_req_no;
    logic          busy;
    logic [NS-1:0] cause;
    logic          timeout;

    rst_req_gen #(.NumSrc(NS), .MinAssertCycles(MIN), .TimeoutCycles(TMO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode),
        .req_i       (req),
        .req_mask_i  (mask),
        .init_ni     (init_ni),
        .rst_req_no  (rst_req_no),
        .busy_o      (busy),
        .cause_o     (cause),
        .cause_clr_i (cause_clr),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] req;
        logic [NS-1:0] mask;
        logic          clr;
        logic          test;
        logic          exp_rst_n;
        logic          exp_busy;
        logic [NS-1:0] exp_cause;
    } vec_t;

    vec_t tbl [9];

    int n_vec = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 asserting, 2 releasing; age = cycles spent in phase
    int            m_phase;
    int            m_age;
    logic [NS-1:0] m_cause;
    logic          m_tmo;
    logic          hist [0:7];
    int            init_mode;
    int            lag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_age   = 0;
        m_cause = 2'b00;
        m_tmo   = 1'b0;
        for (int i = 0; i < 8; i++) hist[i] = 1'b1;
    endtask

    task automatic model_step();
        logic [NS-1:0] eff;
        int            nph;
        int            nage;
        logic          ev;
        eff  = req & ~mask;
        nph  = m_phase;
        nage = m_age + 1;
        ev   = 1'b0;
        if (test_mode) begin
            nph = 0;
        end else if (m_phase == 0) begin
            if (eff != 2'b00) begin
                nph  = 1;
                nage = 1;
            end
        end else if (m_phase == 1) begin
            if (m_age >= MIN && !init_ni) begin
                nph  = 2;
                nage = 1;
            end else if (TMO_EN && m_age >= MIN + TMO) begin
                ev   = 1'b1;
                nph  = 2;
                nage = 1;
            end
        end else begin
            if (init_ni) begin
                nph = 0;
            end else if (TMO_EN && m_age >= TMO) begin
                ev  = 1'b1;
                nph = 0;
            end
        end
        m_cause = (cause_clr ? 2'b00 : m_cause) | eff;
        m_tmo   = ev ? 1'b1 : (cause_clr ? 1'b0 : m_tmo);
        m_phase = nph;
        m_age   = nage;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rst_req_no"}, 32'(rst_req_no), 32'(m_phase != 1));
        chk({tag, ".busy"},       32'(busy),       32'(m_phase != 0));
        chk({tag, ".cause"},      32'(cause),      32'(m_cause));
        chk({tag, ".timeout"},    32'(timeout),    32'(m_tmo));
    endtask

    // one clock cycle: downstream synchronizer model drives init_ni, then edge, then compare
    task automatic tick(input string tag);
        case (init_mode)
            1:       init_ni = 1'b1;
            2:       init_ni = 1'b0;
            default: init_ni = hist[lag];
        endcase
        model_step();
        @(posedge clk);
        #1;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = (m_phase != 1);
        check_model(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rst_req_no"}, 32'(rst_req_no), 32'd1);
        chk({tag, ".busy"},       32'(busy),       32'd0);
        chk({tag, ".cause"},      32'(cause),      32'd0);
        chk({tag, ".timeout"},    32'(timeout),    32'd0);
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        req       = 2'b00;
        mask      = 2'b00;
        cause_clr = 1'b0;
        test_mode = 1'b0;
        init_mode = 0;
        lag       = 0;
        init_ni   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_ni = 1'b1;
    endtask

    // asynchronous reset pulse between clock edges; outputs must clear without an edge
    task automatic pulse_reset(input string tag);
        #2 rst_ni = 1'b0;
        #1;
        chk_reset_vals({tag, ".async_rst"});
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        int low;
        int rise_at;
        int fall_at;
        int t;
        int k;
        logic prev_init;
        logic prev_busy;

        //        req    mask   clr   test  rst_n busy  cause
        tbl[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[1] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[2] = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        tbl[3] = '{2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[4] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[5] = '{2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        tbl[6] = '{2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
        tbl[7] = '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
        tbl[8] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};

        for (int i = 0; i < 9; i++) begin
            do_reset();
            req       = tbl[i].req;
            mask      = tbl[i].mask;
            cause_clr = tbl[i].clr;
            test_mode = tbl[i].test;
            tick($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_rst_n", i), 32'(rst_req_no), 32'(tbl[i].exp_rst_n));
            chk($sformatf("tbl%0d.exp_busy", i),  32'(busy),       32'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d.exp_cause", i), 32'(cause),      32'(tbl[i].exp_cause));
        end

        // single request, synchronizer answering with a 4-cycle lag
        do_reset();
        lag = 4;
        req = 2'b01;
        tick("A");
        req       = 2'b00;
        low       = (rst_req_no == 1'b0) ? 1 : 0;
        rise_at   = -1;
        fall_at   = -1;
        prev_init = init_ni;
        for (int i = 0; i < 40; i++) begin
            prev_busy = busy;
            tick("A");
            if (!rst_req_no) low++;
            if (init_ni && !prev_init && rise_at < 0) rise_at = i;
            prev_init = init_ni;
            if (prev_busy && !busy && fall_at < 0) fall_at = i + 1;
        end
        chk("A.low_cycles", 32'(low), 32'd8);
        chk("A.busy_fall_lag", 32'(fall_at - rise_at), 32'd1);
        chk("A.cause", 32'(cause), 32'd1);

        // synchronizer never acknowledges entry
        do_reset();
        init_mode = 1;
        req = 2'b01;
        tick("B");
        req = 2'b00;
        low = 1;
        for (int i = 0; i < 40; i++) begin
            tick("B");
            if (!rst_req_no) low++;
        end
`ifdef RST_REQ_GEN_TIMEOUT_EN
        chk("B.low_cycles", 32'(low), 32'(MIN + TMO));
        chk("B.timeout", 32'(timeout), 32'd1);
        chk("B.busy", 32'(busy), 32'd0);
        cause_clr = 1'b1;
        tick("B.clr");
        cause_clr = 1'b0;
        chk("B.timeout_clr", 32'(timeout), 32'd0);
`else
        chk("B.low_cycles", 32'(low), 32'd41);
        chk("B.busy", 32'(busy), 32'd1);
        chk("B.timeout", 32'(timeout), 32'd0);
        init_mode = 0;
        lag = 1;
        for (int i = 0; i < 30; i++) tick("B.done");
        chk("B.busy_done", 32'(busy), 32'd0);
`endif

        // masking and no restart on a request raised mid-sequence
        do_reset();
        lag  = 4;
        req  = 2'b11;
        mask = 2'b10;
        tick("C");
        chk("C.cause_masked", 32'(cause), 32'd1);
        low = (rst_req_no == 1'b0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick("C");
            if (!rst_req_no) low++;
        end
        mask = 2'b00;
        tick("C");
        if (!rst_req_no) low++;
        chk("C.cause_late", 32'(cause), 32'd3);
        req = 2'b00;
        for (int i = 0; i < 30; i++) begin
            tick("C");
            if (!rst_req_no) low++;
        end
        chk("C.low_cycles", 32'(low), 32'd8);

        // clear coinciding with a new request on source 1
        cause_clr = 1'b1;
        req       = 2'b10;
        tick("D");
        chk("D.cause", 32'(cause), 32'd2);
        cause_clr = 1'b0;
        req       = 2'b00;
        for (int i = 0; i < 30; i++) tick("D");
        chk("D.busy_done", 32'(busy), 32'd0);

        // test mode during ASSERT
        do_reset();
        lag = 2;
        req = 2'b01;
        for (int i = 0; i < 3; i++) tick("E");
        test_mode = 1'b1;
        tick("E.tm");
        chk("E.tm_rst_n", 32'(rst_req_no), 32'd1);
        chk("E.tm_busy", 32'(busy), 32'd0);
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick("E.tm_hold");
            chk("E.tm_hold_rst_n", 32'(rst_req_no), 32'd1);
        end
        chk("E.tm_cause", 32'(cause), 32'd3);
        test_mode = 1'b0;
        req = 2'b01;
        tick("E.resume");
        chk("E.resume_rst_n", 32'(rst_req_no), 32'd0);
        chk("E.resume_busy", 32'(busy), 32'd1);
        req = 2'b00;
        for (int i = 0; i < 40; i++) tick("E");
        chk("E.busy_done", 32'(busy), 32'd0);

        // asynchronous reset while waiting in RELEASE
        do_reset();
        lag = 2;
        req = 2'b01;
        tick("F");
        req = 2'b00;
        t = 0;
        while (!(busy && rst_req_no) && t < 40) begin
            tick("F");
            t++;
        end
        chk("F.in_release", 32'({busy, rst_req_no}), 32'd3);
        init_mode = 2;
        tick("F");
        tick("F");
        chk("F.still_release", 32'({busy, rst_req_no}), 32'd3);
        pulse_reset("F");
        init_mode = 0;
        lag = 0;

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = NS'($urandom_range(0, 3));
            else if ($urandom_range(0, 1) == 0) req = 2'b00;
            if ($urandom_range(0, 15) == 0) mask = NS'($urandom_range(0, 3));
            cause_clr = ($urandom_range(0, 19) == 0);
            if (test_mode) test_mode = ($urandom_range(0, 7) != 0);
            else test_mode = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) begin
                k = $urandom_range(0, 9);
                if (k < 7) begin
                    init_mode = 0;
                    lag = $urandom_range(0, 6);
                end else if (k < 9) begin
                    init_mode = 1;
                end else begin
                    init_mode = 2;
                end
            end
            if ($urandom_range(0, 699) == 0) pulse_reset("rnd");
            else tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
